// File: rtl/serdes_pkg.sv
// serdes_pkg: shared types and constants for the serializer/deserializer pair
// Contents: ser_state_t FSM encoding, BIT_ORDER_* values for the MSB_FIRST parameter
package serdes_pkg;
    typedef enum logic {IDLE, SHIFT} ser_state_t;
    localparam bit BIT_ORDER_LSB = 1'b0;
    localparam bit BIT_ORDER_MSB = 1'b1;
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with valid/ready word input
// Ports: i_clk/i_rst clock and sync active-high reset; i_valid/i_word/o_ready word handshake;
//        o_dout/o_dout_valid/o_last serial bit stream with end-of-word marker; o_busy word in flight
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int LENGTH    = 8,
    parameter bit MSB_FIRST = BIT_ORDER_LSB
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [LENGTH-1:0] i_word,
    output logic              o_ready,
    output logic              o_dout,
    output logic              o_dout_valid,
    output logic              o_last,
    output logic              o_busy
);
    localparam int CW = $clog2(LENGTH);

    ser_state_t        state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [LENGTH-1:0] shreg;
    logic              accept;

    // Outputs are gated by i_rst so an aborted frame goes quiet in the reset cycle itself.
    always_comb begin
        o_busy       = (state == SHIFT) && !i_rst;
        o_dout_valid = o_busy;
        o_last       = o_busy && (cnt == CW'(LENGTH - 1));
        o_ready      = ((state == IDLE) || o_last) && !i_rst;
        o_dout       = o_busy ? (MSB_FIRST ? shreg[LENGTH-1] : shreg[0]) : 1'b0;
        accept       = i_valid && o_ready;
        state_nxt    = accept ? SHIFT : (o_last ? IDLE : state);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                shreg <= i_word;
                cnt   <= '0;
            end else if (o_busy) begin
                shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                cnt   <= o_last ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized and directed check of both bit orders against a bit-queue model
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] word = 8'h00;
    logic       rdy_l, dout_l, dv_l, last_l, busy_l;
    logic       rdy_m, dout_m, dv_m, last_m, busy_m;
    int         errors = 0;
    int         checks = 0;
    bit         q_l[$];
    bit         q_m[$];
    logic [7:0] cap_l = 8'h00;
    logic [7:0] cap_m = 8'h00;

    always #5 clk = ~clk;

    piso_serializer #(.LENGTH(8), .MSB_FIRST(1'b0)) dut_l (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_word(word),
        .o_ready(rdy_l), .o_dout(dout_l), .o_dout_valid(dv_l), .o_last(last_l), .o_busy(busy_l)
    );

    piso_serializer #(.LENGTH(8), .MSB_FIRST(1'b1)) dut_m (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_word(word),
        .o_ready(rdy_m), .o_dout(dout_m), .o_dout_valid(dv_m), .o_last(last_m), .o_busy(busy_m)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs follow from the bits still owed for the word in flight.
    task automatic check_dut(input string t, input bit q[$], input logic d, input logic dv,
                             input logic l, input logic b, input logic r);
        bit act;
        act = (q.size() > 0) && !rst;
        chk({t, "_valid"}, dv, act);
        chk({t, "_busy"}, b, act);
        chk({t, "_dout"}, d, act ? q[0] : 1'b0);
        chk({t, "_last"}, l, act && (q.size() == 1));
        chk({t, "_ready"}, r, (q.size() <= 1) && !rst);
    endtask

    task automatic tick();
        bit acc;
        @(negedge clk);
        check_dut("lsb", q_l, dout_l, dv_l, last_l, busy_l, rdy_l);
        check_dut("msb", q_m, dout_m, dv_m, last_m, busy_m, rdy_m);
        if (dv_l) cap_l = {dout_l, cap_l[7:1]};
        if (dv_m) cap_m = {cap_m[6:0], dout_m};
        @(posedge clk);
        acc = valid && (q_l.size() <= 1) && !rst;
        if (rst) begin
            q_l.delete();
            q_m.delete();
        end else begin
            if (q_l.size() > 0) void'(q_l.pop_front());
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (acc)
                for (int i = 0; i < 8; i++) begin
                    q_l.push_back(word[i]);
                    q_m.push_back(word[7-i]);
                end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_one(input logic [7:0] w, input int idle);
        valid = 1'b1;
        word  = w;
        tick();
        valid = 1'b0;
        word  = 8'($urandom);
        ticks(idle);
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b1;
        word = 8'hFF;
        ticks(2);
        rst = 1'b0;
        valid = 1'b0;
        ticks(20);
        send_one(8'hA5, 10);
        chk("single_lsb_word", cap_l, 8'hA5);
        chk("single_msb_word", cap_m, 8'hA5);
        send_one(8'h01, 10);
        chk("msb_01_word", cap_m, 8'h01);
        chk("lsb_01_word", cap_l, 8'h01);
        valid = 1'b1;
        word = 8'hA5;
        tick();
        word = 8'h3C;
        ticks(8);
        valid = 1'b0;
        ticks(10);
        chk("b2b_lsb_second", cap_l, 8'h3C);
        chk("b2b_msb_second", cap_m, 8'h3C);
        send_one(8'hFF, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(12);
        valid = 1'b1;
        word = 8'hC3;
        tick();
        for (int i = 0; i < 7; i++) begin
            word = 8'($urandom);
            tick();
        end
        valid = 1'b0;
        ticks(10);
        chk("ignore_midword_lsb", cap_l, 8'hC3);
        chk("ignore_midword_msb", cap_m, 8'hC3);
        for (int i = 0; i < 3000; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            word  = 8'($urandom);
            rst   = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        valid = 1'b0;
        ticks(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
